// File: rtl/mod_inv_seq_pkg.sv
// Shared constants for the sequential modular inverse: operand width, watchdog bound, state codes.
package mod_inv_seq_pkg;

  localparam int unsigned len     = 32;
  localparam int unsigned MAX_CYC = 4 * len;
  localparam int unsigned CntW    = $clog2(MAX_CYC + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;
  localparam logic [1:0] StCheck = 2'd3;

  // Operands for which the iteration is undefined or cannot converge.
  function automatic logic illegal_operands(input logic [len-1:0] a, input logic [len-1:0] r);
    return (a == '0) || (a >= r) || !r[0] || (r < len'(3));
  endfunction

endpackage

// File: rtl/mod_half.sv
// Modular halving: x/2 mod r for odd r, with the (x+r) sum carried in len+1 bits.
module mod_half
  import mod_inv_seq_pkg::*;
(
  input  logic [len-1:0] x,
  input  logic [len-1:0] r,
  output logic [len-1:0] y
);

  logic [len:0] sum;
  logic         unused_lsb;

  assign sum = {1'b0, x} + (x[0] ? {1'b0, r} : '0);
  assign {y, unused_lsb} = sum;

endmodule

// File: rtl/mod_mul.sv
// Combinational (a*b) mod r; only built when MOD_INV_VERIFY_EN is defined.
`ifdef MOD_INV_VERIFY_EN
module mod_mul
  import mod_inv_seq_pkg::*;
(
  input  logic [len-1:0] a,
  input  logic [len-1:0] b,
  input  logic [len-1:0] r,
  output logic [len-1:0] p
);

  logic [2*len-1:0] prod;
  logic [2*len-1:0] rem;
  logic [len-1:0]   unused_hi;

  assign prod = {{len{1'b0}}, a} * {{len{1'b0}}, b};
  assign rem  = prod % {{len{1'b0}}, r};
  assign {unused_hi, p} = rem;

endmodule
`endif

// File: rtl/mod_inv_seq.sv
// Sequential a^-1 mod r via binary extended Euclid, one step per clock.
// Define MOD_INV_VERIFY_EN to add a CHECK state that re-multiplies the result.
module mod_inv_seq
  import mod_inv_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [len-1:0] a,
  input  logic [len-1:0] r,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [len-1:0] c,
  output logic           err
);

  logic [1:0]      state_q, state_d;
  logic [len-1:0]  r_q, r_d, u_q, u_d, v_q, v_d;
  logic [len-1:0]  x1_q, x1_d, x2_q, x2_d, c_q, c_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [len-1:0]  x1_half, x2_half, x1_sub, x2_sub;

  mod_half u_half_x1 (.x(x1_q), .r(r_q), .y(x1_half));
  mod_half u_half_x2 (.x(x2_q), .r(r_q), .y(x2_half));

  // Wrap-around arithmetic is exact here: the true difference always lies in [0, r-1].
  assign x1_sub = x1_q - x2_q + ((x1_q >= x2_q) ? '0 : r_q);
  assign x2_sub = x2_q - x1_q + ((x2_q >= x1_q) ? '0 : r_q);

`ifdef MOD_INV_VERIFY_EN
  logic [len-1:0] a_q, a_d, prod;
  localparam logic [1:0] StSuccess = StCheck;
  mod_mul u_mul (.a(c_q), .b(a_q), .r(r_q), .p(prod));
`else
  localparam logic [1:0] StSuccess = StDone;
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    c_d     = c_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef MOD_INV_VERIFY_EN
    a_d     = a_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
`ifdef MOD_INV_VERIFY_EN
          a_d = a;
`endif
          r_d   = r;
          c_d   = '0;
          if (illegal_operands(a, r)) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            err_d   = 1'b0;
            u_d     = a;
            v_d     = r;
            x1_d    = len'(1);
            x2_d    = '0;
            cnt_d   = '0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        if (u_q == len'(1)) begin
          c_d     = x1_q;
          state_d = StSuccess;
        end else if (v_q == len'(1)) begin
          c_d     = x2_q;
          state_d = StSuccess;
        end else if ((u_q == '0) || (v_q == '0) || (cnt_q == CntW'(MAX_CYC))) begin
          err_d   = 1'b1;
          c_d     = '0;
          state_d = StDone;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = x1_half;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = x2_half;
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = x1_sub;
        end else begin
          v_d  = v_q - u_q;
          x2_d = x2_sub;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
`ifdef MOD_INV_VERIFY_EN
      StCheck: begin
        if (prod != len'(1)) begin
          err_d = 1'b1;
          c_d   = '0;
        end
        state_d = StDone;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef MOD_INV_VERIFY_EN
      a_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      c_q     <= c_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef MOD_INV_VERIFY_EN
      a_q     <= a_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign c         = c_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mod_inv_seq.sv
// Directed vector bench for mod_inv_seq: table of operands plus backpressure and reset sequences.
module tb_mod_inv_seq;

  localparam int unsigned Len   = 32;
  localparam int          Bound = 4 * Len + 4;
  localparam logic [31:0] P31   = 32'd2147483647;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] r = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] c;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  mod_inv_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .r(r),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] r;
    logic [31:0] c;        // expected result (ignored when chk_mul is set)
    logic        err;
    logic        chk_mul;  // check (a*c) mod r == 1 instead of a fixed c
    int          lat;      // exact cycles accept->out_valid, 0 = only bound-checked
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one operation and wait for out_valid; result is left in DONE (not popped).
  task automatic run_op(input logic [31:0] av, input logic [31:0] rv, output int cyc,
                        output logic ready_bad, output logic timeout);
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1;
    a = av;
    r = rv;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    ready_bad = 1'b0;
    while (!out_valid && cyc < Bound) begin
      if (in_ready) ready_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (in_ready) ready_bad = 1'b1;
    timeout = !out_valid;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  vec_t vecs[10];
  int   cyc;
  logic rb, to;
  logic [63:0] prod;

  initial begin
    vecs[0] = '{a: 32'd3,         r: 32'd7,  c: 32'd5,          err: 1'b0, chk_mul: 1'b0, lat: 0};
    vecs[1] = '{a: 32'd2,         r: P31,    c: 32'd1073741824, err: 1'b0, chk_mul: 1'b0, lat: 0};
    vecs[2] = '{a: 32'd290987904, r: P31,    c: 32'd0,          err: 1'b0, chk_mul: 1'b1, lat: 0};
    vecs[3] = '{a: 32'd1,         r: P31,    c: 32'd1,          err: 1'b0, chk_mul: 1'b0, lat: 0};
    vecs[4] = '{a: P31 - 32'd1,   r: P31,    c: P31 - 32'd1,    err: 1'b0, chk_mul: 1'b0, lat: 0};
    vecs[5] = '{a: 32'd6,         r: 32'd15, c: 32'd0,          err: 1'b1, chk_mul: 1'b0, lat: 0};
    vecs[6] = '{a: 32'd0,         r: 32'd7,  c: 32'd0,          err: 1'b1, chk_mul: 1'b0, lat: 1};
    vecs[7] = '{a: 32'd3,         r: 32'd10, c: 32'd0,          err: 1'b1, chk_mul: 1'b0, lat: 1};
    vecs[8] = '{a: 32'd7,         r: 32'd7,  c: 32'd0,          err: 1'b1, chk_mul: 1'b0, lat: 1};
    vecs[9] = '{a: 32'd4,         r: 32'd9,  c: 32'd7,          err: 1'b0, chk_mul: 1'b0, lat: 0};

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c", c, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].r, cyc, rb, to);
      chk($sformatf("v%0d_done_in_bound", i), to, 0);
      chk($sformatf("v%0d_in_ready_low", i), rb, 0);
      if (vecs[i].lat != 0) chk($sformatf("v%0d_latency", i), cyc, vecs[i].lat);
      chk($sformatf("v%0d_err", i), err, vecs[i].err);
      if (vecs[i].chk_mul) begin
        prod = (64'(vecs[i].a) * 64'(c)) % 64'(vecs[i].r);
        chk($sformatf("v%0d_inv_product", i), prod, 1);
        chk($sformatf("v%0d_c_below_r", i), c < vecs[i].r, 1);
      end else begin
        chk($sformatf("v%0d_c", i), c, vecs[i].c);
      end
      pop();
      chk($sformatf("v%0d_back_idle", i), in_ready, 1);
    end

    // Backpressure: result held, new operands ignored while DONE
    run_op(32'd3, 32'd7, cyc, rb, to);
    chk("bp_done", to, 0);
    in_valid = 1'b1;
    a = 32'd2;
    r = 32'd11;
    begin
      logic held_ok;
      held_ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (!out_valid || in_ready || c !== 32'd5 || err !== 1'b0) held_ok = 1'b0;
      end
      chk("bp_held_stable", held_ok, 1);
    end
    in_valid = 1'b0;
    pop();
    chk("bp_out_valid_drop", out_valid, 0);
    chk("bp_in_ready_rise", in_ready, 1);
    chk("bp_c_kept", c, 5);
    run_op(32'd2, 32'd11, cyc, rb, to);
    chk("bp_next_done", to, 0);
    chk("bp_next_c", c, 6);
    chk("bp_next_err", err, 0);
    pop();

    // Reset mid-RUN
    in_valid = 1'b1;
    a = 32'd290987904;
    r = P31;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_in_run", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_c", c, 0);
    chk("mid_rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'd3, 32'd7, cyc, rb, to);
    chk("post_rst_done", to, 0);
    chk("post_rst_c", c, 5);
    chk("post_rst_err", err, 0);
    pop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_inv_seq.md
Name: mod_inv_seq

Overview:
- Sequential modular inverse: given a and odd modulus r, computes c = a^-1 mod r.
- Uses the binary extended Euclidean algorithm, one reduction step per clock.
- It is the inverse-direction counterpart of the combinational mod_mul, and supplies the inverses needed by the Schnorr signing and verification datapaths, e.g. k^-1 mod q.
- Valid/ready handshake on both input and output; one operation in flight.

Parameters:
- len, from parameters.vh (32): width of a, r and c.
- MAX_CYC, 4*len: watchdog bound on RUN cycles; exceeding it raises err.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operands presented.
- in_ready  output  1  block idle and able to accept.
- a  input  len  value to invert; must satisfy a < r.
- r  input  len  modulus; must be odd and >= 3.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- c  output  len  inverse; 0 when err=1.
- err  output  1  no inverse exists or input is illegal.

Behaviour:
- Reset values: in_ready=1, out_valid=0, c=0, err=0, state=IDLE; internal registers u, v, x1, x2, cnt all cleared.
- Reset mid-operation aborts the computation with no output.
- States: IDLE, RUN, DONE (plus CHECK when the optional feature is enabled).
- IDLE: in_ready=1. An accept occurs when in_valid && in_ready.
  - Operands a and r are latched on accept.
  - If a==0, a>=r, r even or r<3: go straight to DONE with err=1, c=0. No RUN cycles.
  - Otherwise load u=a, v=r, x1=1, x2=0, cnt=0 and go to RUN.
- RUN: exactly one action per cycle, checked in this priority order:
  1. u==1: c=x1, go to DONE. Else if v==1: c=x2, go to DONE.
  2. u==0 or v==0 (gcd>1): err=1, c=0, go to DONE.
  3. u even: u=u>>1; x1 = x1 even ? x1>>1 : (x1+r)>>1.
  4. else v even: v=v>>1; same halving rule applied to x2.
  5. else u>=v: u=u-v; x1 = x1>=x2 ? x1-x2 : x1+r-x2.
  6. else: v=v-u; x2 = x2>=x1 ? x2-x1 : x2+r-x1.
  - cnt increments each RUN cycle. If cnt reaches MAX_CYC: err=1, go to DONE.
- Width rules:
  - The (x+r) sums are computed in len+1 bits; the >>1 result fits in len bits.
  - x1 and x2 always stay in [0, r-1].
- DONE: out_valid=1; c and err are held stable while out_ready=0.
  - On out_valid && out_ready, go to IDLE next cycle; out_valid drops and in_ready rises.
  - c and err keep their values until the next accept.
- in_ready=0 in RUN, DONE and CHECK. in_valid is ignored there and no input is queued.
- Latency: the illegal-input path reaches DONE 1 cycle after accept. Legal inputs take at most 4*len RUN cycles.

Optional Feature:
- MOD_INV_VERIFY_EN defined:
  - A mod_mul instance computes c*a mod r from the latched a and r.
  - On a successful RUN exit the FSM enters CHECK for 1 cycle, then DONE.
  - If the product != 1, err=1 and c=0.
  - Latency is +1 cycle on the success path only.
- Undefined: no CHECK state and no mod_mul instance; RUN exits directly to DONE.

Decomposition:
- parameters.vh: len, MAX_CYC default, state encodings.
- Sub-module mod_half (combinational): inputs x, r; output = x even ? x>>1 : (x+r)>>1.
  - Instantiated twice, once for x1 and once for x2.
- Modular subtraction stays inline in mod_inv_seq.

Test Plan:
- r=7, a=3 -> c=5, err=0. Check out_valid is asserted within 4*len cycles and in_ready=0 throughout.
- r=2147483647: a=2 -> c=1073741824; a=290987904 -> c with (a*c) mod r == 1, cross-checked by mod_mul in the bench.
- Edge values, r=2147483647: a=1 -> c=1; a=r-1 -> c=r-1.
- Illegal inputs:
  - r=15, a=6 -> err=1, c=0 (gcd 3).
  - a=0 -> err=1 after 1 cycle.
  - r=10 (even) -> err=1.
  - a=7, r=7 -> err=1.
- Backpressure: hold out_ready=0 for 20 cycles -> c/err stable and in_valid ignored; raise out_ready -> IDLE next cycle, and a new operand is accepted.
- Assert rst mid-RUN -> all outputs return to reset values immediately; a subsequent r=7, a=3 still gives c=5.
